// File: rtl/div5_pkg.sv
// Residue encoding and transition function for bit-serial divide-by-5 tracking.
// Shared by the stream transmitter and the serial checker.
package div5_pkg;

  typedef logic [2:0] residue_t;

  localparam residue_t R0 = 3'b000;
  localparam residue_t R1 = 3'b001;
  localparam residue_t R2 = 3'b010;
  localparam residue_t R3 = 3'b011;
  localparam residue_t R4 = 3'b100;

  // r' = (2r + b) mod 5; unused codes fall back to R0.
  function automatic residue_t next_residue(residue_t r, logic b);
    residue_t res;
    case (r)
      R0:      res = b ? R1 : R0;
      R1:      res = b ? R3 : R2;
      R2:      res = b ? R0 : R4;
      R3:      res = b ? R2 : R1;
      R4:      res = b ? R4 : R3;
      default: res = R0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/div5_stream_tx_if.sv
// Load handshake and serial output bundle of the divide-by-5 stream transmitter.
interface div5_stream_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             exp_div5;
  logic             busy;

  // Producer / observer side.
  modport master (
    output load_valid, load_data,
    input  load_ready, ser_out, ser_valid, ser_last, exp_div5, busy
  );

  // Transmitter side.
  modport slave (
    input  load_valid, load_data,
    output load_ready, ser_out, ser_valid, ser_last, exp_div5, busy
  );
endinterface

// File: rtl/div5_residue.sv
// Registered running residue (prefix mod 5) of a bit stream; clr restarts from R0.
module div5_residue
  import div5_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     en,
  input  logic     bit_val,
  output residue_t residue,
  output logic     zero
);

  residue_t residue_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      residue_q <= R0;
    end else if (clr) begin
      // Clear and first-bit update may coincide on word acceptance.
      residue_q <= en ? next_residue(R0, bit_val) : R0;
    end else if (en) begin
      residue_q <= next_residue(residue_q, bit_val);
    end
  end

  assign residue = residue_q;
  assign zero    = (residue_q == R0);

endmodule

// File: rtl/div5_stream_tx.sv
// MSB-first serial transmitter with a valid/ready load port and a per-bit
// "prefix divisible by 5" reference flag.
module div5_stream_tx
  import div5_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  div5_stream_tx_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] nxt_shift;
  logic             shifting;
  logic             last_bit;
  logic             accept;
  logic             res_en;
  logic             res_bit;
  residue_t         residue;
  logic             res_zero;

  assign shifting  = (state_q == StShift);
  assign last_bit  = shifting && (cnt_q == '0);
  assign nxt_shift = shift_q << 1;

  assign bus.load_ready = !shifting || last_bit;
  assign accept         = bus.load_valid && bus.load_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = StShift;
      shift_d = bus.load_data;
      cnt_d   = CntW'(WIDTH - 1);
    end else if (last_bit) begin
      state_d = StIdle;
    end else if (shifting) begin
      shift_d = nxt_shift;
      cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The residue register runs one step ahead so it already covers the bit
  // being presented: it absorbs the MSB on acceptance and each next bit on a shift.
  assign res_en  = accept || (shifting && !last_bit);
  assign res_bit = accept ? bus.load_data[WIDTH-1] : nxt_shift[WIDTH-1];

  div5_residue u_residue (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (res_en),
    .bit_val (res_bit),
    .residue (residue),
    .zero    (res_zero)
  );

  assign bus.ser_out   = shifting && shift_q[WIDTH-1];
  assign bus.ser_valid = shifting;
  assign bus.ser_last  = last_bit;
  assign bus.exp_div5  = shifting && res_zero;
  assign bus.busy      = shifting;

endmodule

// File: tb/tb_div5_stream_tx.sv
// Directed and randomized checks of div5_stream_tx against a prefix-arithmetic model.
module tb_div5_stream_tx;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div5_stream_tx_if #(.WIDTH(W)) bus ();

  div5_stream_tx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.ser_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
    chk({tag, "_last"}, 32'(bus.ser_last), 32'd0);
    chk({tag, "_exp"}, 32'(bus.exp_div5), 32'd0);
    chk({tag, "_out"}, 32'(bus.ser_out), 32'd0);
  endtask

  // Offer a word while the block is expected to be ready; it is taken on the next edge.
  task automatic load(input logic [W-1:0] w);
    chk("load_ready", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    tick();
    bus.load_valid = 1'b0;
  endtask

  // Check one in-flight word bit by bit. Expected bit i is the low bit of the
  // prefix w >> (W-1-i); the flag is that prefix's divisibility by 5.
  task automatic expect_word(input logic [W-1:0] w, input bit chain,
                             input logic [W-1:0] nw, input bit intr);
    for (int i = 0; i < int'(W); i++) begin
      int unsigned prefix;
      prefix = 32'(w) >> (W - 1 - i);
      chk("ser_valid", 32'(bus.ser_valid), 32'd1);
      chk("ser_out", 32'(bus.ser_out), prefix & 1);
      chk("exp_div5", 32'(bus.exp_div5), 32'((prefix % 5) == 0));
      chk("ser_last", 32'(bus.ser_last), 32'(i == int'(W) - 1));
      chk("ready_shift", 32'(bus.load_ready), 32'(i == int'(W) - 1));
      chk("busy", 32'(bus.busy), 32'd1);
      if (i == int'(W) - 1) begin
        bus.load_valid = chain;
        bus.load_data  = nw;
      end else begin
        bus.load_valid = intr && (i >= 1);
        bus.load_data  = 8'h3C;
      end
      tick();
    end
    bus.load_valid = 1'b0;
    if (!chain) chk_idle("end_of_word");
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] nw;
    bit           chain;
    logic         s_out, s_exp, s_ready;

    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    rst = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    load(8'd10);
    expect_word(8'd10, 1'b0, '0, 1'b0);

    load(8'd7);
    expect_word(8'd7, 1'b1, 8'd255, 1'b0);
    expect_word(8'd255, 1'b0, '0, 1'b0);

    // Reset during bit 3 drops the rest of the word.
    load(8'hA5);
    chk("a5_b1", 32'(bus.ser_out), 32'd1);
    tick();
    chk("a5_b2", 32'(bus.ser_out), 32'd0);
    tick();
    chk("a5_b3", 32'(bus.ser_out), 32'd1);
    chk("a5_b3_valid", 32'(bus.ser_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid_reset");
    load(8'd5);
    expect_word(8'd5, 1'b0, '0, 1'b0);

    // Load pulses during bits 2-7 must be ignored.
    w = 8'($urandom);
    load(w);
    expect_word(w, 1'b0, '0, 1'b1);

    s_out   = bus.ser_out;
    s_exp   = bus.exp_div5;
    s_ready = bus.load_ready;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_valid", 32'(bus.ser_valid), 32'd0);
      chk("idle_static", 32'({bus.ser_out, bus.exp_div5, bus.load_ready}),
          32'({s_out, s_exp, s_ready}));
    end

    // Randomized words, back-to-back or separated by idle cycles.
    w = 8'($urandom);
    load(w);
    for (int n = 0; n < 40; n++) begin
      chain = 1'($urandom);
      nw    = 8'($urandom);
      expect_word(w, chain, nw, 1'($urandom));
      if (!chain) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        load(nw);
      end
      w = nw;
    end
    expect_word(w, 1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
